icache_sa: RTL and testbench

Parametrised set-associative, read-only instruction cache with an explicit miss/fill state machine, multi-beat line refill, replacement policy and whole-cache flush. It sits between the fetch stage (request/response port) and the system memory bus (fill port). It supersedes the fixed 4-way, 512-bit single-lookup cache. Tag/valid state and line storage are internal register arrays.

---
 rtl/icache_sa.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_icache_sa.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_sa.sv
// -----------------------------------------------------------------------------
// icache_sa -- set-associative, read-only instruction cache
//
// Sits between the fetch stage and the system memory bus. Each request does one
// lookup. A miss refills one whole line as BEATS bus beats, writes it into a
// victim way and then returns it. Tags, valid bits and line data are internal
// register arrays. A flush clears the cache one set per cycle.
//
// Optional feature macro: ICACHE_LRU_EN
//   defined   : true LRU per set (LOG_WAYS-bit age per way).
//   undefined : per-set round-robin pointer that advances on each eviction fill.
//
// Ports
//   clk, reset_n          rising-edge clock, synchronous active-low reset
//   req_valid/req_ready   fetch request handshake, req_addr = byte address
//   resp_valid            one-cycle pulse; resp_block/resp_hit held until the
//                         next response (resp_hit: 1 = hit, 0 = filled)
//   flush                 invalidate the whole cache (deferred while busy)
//   mem_req/mem_addr      fill request for a line-aligned address, held until
//                         the last beat has been taken
//   mem_data_valid/mem_data  fill beats in ascending order, beat 0 = low bytes
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE, with no flush requested or pending.
// Responses cannot be stalled. Fill beats transfer on each edge where
// mem_data_valid is high while mem_req is high; beats at any other time are
// ignored.
// -----------------------------------------------------------------------------
module icache_sa #(
    parameter int ADDR_W   = 64,
    parameter int LOG_LINE = 6,
    parameter int LOG_WAYS = 2,
    parameter int LOG_SETS = 5,
    parameter int BUS_W    = 64,
    localparam int LINE_BITS = 8 << LOG_LINE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    input  logic [ADDR_W-1:0]    req_addr,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic [LINE_BITS-1:0] resp_block,
    output logic                 resp_hit,
    input  logic                 flush,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_data_valid,
    input  logic [BUS_W-1:0]     mem_data
);

    localparam int WAYS   = 1 << LOG_WAYS;
    localparam int SETS   = 1 << LOG_SETS;
    localparam int BEATS  = LINE_BITS / BUS_W;
    localparam int BCW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TAG_W  = ADDR_W - LOG_LINE - LOG_SETS;
    localparam int LADDR_W = ADDR_W - LOG_LINE;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        FILL   = 3'd2,
        RESP   = 3'd3,
        FLUSH  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [LADDR_W-1:0]     line_addr_q, line_addr_d;
    logic [BCW-1:0]         beat_cnt_q, beat_cnt_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [LOG_SETS-1:0]    flush_cnt_q, flush_cnt_d;
    logic [LOG_WAYS-1:0]    victim_q, victim_d;
    logic                   evict_q, evict_d;
    logic [LINE_BITS-1:0]   line_buf_q, line_buf_d;
    logic [LINE_BITS-1:0]   resp_block_q, resp_block_d;
    logic                   resp_hit_q, resp_hit_d;
    logic [WAYS-1:0]        valid_q [SETS];
    logic [WAYS-1:0]        valid_d [SETS];

`ifdef ICACHE_LRU_EN
    logic [LOG_WAYS-1:0]    age_q [SETS][WAYS];
    logic [LOG_WAYS-1:0]    age_d [SETS][WAYS];
`else
    logic [LOG_WAYS-1:0]    rr_q [SETS];
    logic [LOG_WAYS-1:0]    rr_d [SETS];
`endif

    // Line storage; validity is tracked by valid_q, so no reset is needed.
    logic [TAG_W-1:0]       tag_mem  [SETS][WAYS];
    logic [LINE_BITS-1:0]   data_mem [SETS][WAYS];

    logic [LOG_SETS-1:0]    idx;
    logic [TAG_W-1:0]       tag;
    logic                   hit;
    logic [LOG_WAYS-1:0]    hit_way;
    logic                   inv_found;
    logic [LOG_WAYS-1:0]    inv_way;
    logic [LOG_WAYS-1:0]    pol_victim;
    logic                   wr_en;
    logic                   touch_en;
    logic [LOG_WAYS-1:0]    touch_way;

    logic unused_offset;
    assign unused_offset = ^req_addr[LOG_LINE-1:0];

    assign idx        = line_addr_q[LOG_SETS-1:0];
    assign tag        = line_addr_q[LADDR_W-1:LOG_SETS];
    assign mem_addr   = {line_addr_q, {LOG_LINE{1'b0}}};
    assign resp_block = resp_block_q;
    assign resp_hit   = resp_hit_q;

    // Tag compare across the indexed set, plus lowest invalid way.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_mem[idx][w] == tag) && !hit) begin
                hit     = 1'b1;
                hit_way = LOG_WAYS'(w);
            end
            if (!valid_q[idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = LOG_WAYS'(w);
            end
        end
    end

    // Replacement candidate when every way of the set is valid.
`ifdef ICACHE_LRU_EN
    always_comb begin
        pol_victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[idx][w] == LOG_WAYS'(WAYS - 1)) begin
                pol_victim = LOG_WAYS'(w);
            end
        end
    end
`else
    assign pol_victim = rr_q[idx];
    logic unused_touch;
    assign unused_touch = touch_en ^ (^touch_way);
`endif

    // Next-state and outputs.
    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        beat_cnt_d   = beat_cnt_q;
        flush_pend_d = flush_pend_q;
        flush_cnt_d  = flush_cnt_q;
        victim_d     = victim_q;
        evict_d      = evict_q;
        line_buf_d   = line_buf_q;
        resp_block_d = resp_block_q;
        resp_hit_d   = resp_hit_q;
        valid_d      = valid_q;
`ifdef ICACHE_LRU_EN
        age_d        = age_q;
`else
        rr_d         = rr_q;
`endif
        wr_en        = 1'b0;
        touch_en     = 1'b0;
        touch_way    = '0;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_req      = 1'b0;

        case (state_q)
            IDLE: begin
                // A flush wins over a request arriving in the same cycle.
                if (flush || flush_pend_q) begin
                    state_d      = FLUSH;
                    flush_pend_d = 1'b0;
                    flush_cnt_d  = '0;
                end else begin
                    req_ready = reset_n;
                    if (req_valid) begin
                        line_addr_d = req_addr[ADDR_W-1:LOG_LINE];
                        state_d     = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                flush_pend_d = flush_pend_q | flush;
                if (hit) begin
                    resp_block_d = data_mem[idx][hit_way];
                    resp_hit_d   = 1'b1;
                    touch_en     = 1'b1;
                    touch_way    = hit_way;
                    state_d      = RESP;
                end else begin
                    victim_d   = inv_found ? inv_way : pol_victim;
                    evict_d    = !inv_found;
                    beat_cnt_d = '0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                mem_req      = 1'b1;
                flush_pend_d = flush_pend_q | flush;
                if (mem_data_valid) begin
                    line_buf_d[int'(beat_cnt_q) * BUS_W +: BUS_W] = mem_data;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == BCW'(BEATS - 1)) begin
                        wr_en                 = 1'b1;
                        valid_d[idx][victim_q] = 1'b1;
                        resp_block_d          = line_buf_d;
                        resp_hit_d            = 1'b0;
                        touch_en              = 1'b1;
                        touch_way             = victim_q;
                        beat_cnt_d            = '0;
                        state_d               = RESP;
`ifndef ICACHE_LRU_EN
                        // The pointer only moves when a valid line is replaced.
                        if (evict_q) begin
                            rr_d[idx] = rr_q[idx] + 1'b1;
                        end
`endif
                    end
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (flush || flush_pend_q) begin
                    state_d      = FLUSH;
                    flush_pend_d = 1'b0;
                    flush_cnt_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                valid_d[flush_cnt_q] = '0;
`ifdef ICACHE_LRU_EN
                for (int w = 0; w < WAYS; w++) begin
                    age_d[flush_cnt_q][w] = LOG_WAYS'(w);
                end
`else
                rr_d[flush_cnt_q] = '0;
`endif
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == LOG_SETS'(SETS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef ICACHE_LRU_EN
        // Accessed way becomes youngest; ways younger than it age by one.
        if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (LOG_WAYS'(w) == touch_way) begin
                    age_d[idx][w] = '0;
                end else if (age_q[idx][w] < age_q[idx][touch_way]) begin
                    age_d[idx][w] = age_q[idx][w] + 1'b1;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            line_addr_q  <= '0;
            beat_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            flush_cnt_q  <= '0;
            victim_q     <= '0;
            evict_q      <= 1'b0;
            line_buf_q   <= '0;
            resp_block_q <= '0;
            resp_hit_q   <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
`ifdef ICACHE_LRU_EN
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= LOG_WAYS'(w);
                end
`else
                rr_q[s] <= '0;
`endif
            end
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            beat_cnt_q   <= beat_cnt_d;
            flush_pend_q <= flush_pend_d;
            flush_cnt_q  <= flush_cnt_d;
            victim_q     <= victim_d;
            evict_q      <= evict_d;
            line_buf_q   <= line_buf_d;
            resp_block_q <= resp_block_d;
            resp_hit_q   <= resp_hit_d;
            valid_q      <= valid_d;
`ifdef ICACHE_LRU_EN
            age_q        <= age_d;
`else
            rr_q         <= rr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            tag_mem[idx][victim_q]  <= tag;
            data_mem[idx][victim_q] <= line_buf_d;
        end
    end

endmodule

// File: tb/tb_icache_sa.sv
// -----------------------------------------------------------------------------
// tb_icache_sa -- bench for icache_sa. A reference model tracks cache contents
// per set (lines per way, recency list or round-robin pointer). A memory
// responder serves fills from a fixed address-to-data function. Expected
// responses go into exp_q, and a monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_icache_sa;
    localparam int LINE_BITS = 512;
    localparam int BEATS     = 8;
    localparam int WAYS      = 4;
    localparam int SETS      = 32;
    localparam int EW        = 1 + 8 + 32 + LINE_BITS;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 req_valid = 1'b0;
    logic [63:0]          req_addr = '0;
    logic                 req_ready;
    logic                 resp_valid;
    logic [LINE_BITS-1:0] resp_block;
    logic                 resp_hit;
    logic                 flush = 1'b0;
    logic                 mem_req;
    logic [63:0]          mem_addr;
    logic                 mem_data_valid = 1'b0;
    logic [63:0]          mem_data = '0;

    icache_sa dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_block(resp_block), .resp_hit(resp_hit),
        .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data_valid(mem_data_valid), .mem_data(mem_data)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    int gap_mode = 0;
    logic [63:0] fill_exp_addr = '0;
    int beat_idx = 0;
    int last_beat_cyc = 0;

    task automatic check(input string name, input logic [LINE_BITS-1:0] act,
                         input logic [LINE_BITS-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // ---------------- memory contents ----------------
    function automatic logic [63:0] mem_word(input logic [63:0] line_addr, input int i);
        return (line_addr - 64'h1000) * 64'h9E3779B97F4A7C15 + 64'(i);
    endfunction

    function automatic logic [LINE_BITS-1:0] exp_line(input logic [63:0] line_addr);
        logic [LINE_BITS-1:0] b;
        for (int i = 0; i < BEATS; i++) b[i*64 +: 64] = mem_word(line_addr, i);
        return b;
    endfunction

    // ---------------- reference model ----------------
    bit          m_valid [SETS][WAYS];
    logic [63:0] m_line  [SETS][WAYS];
    int          m_rec   [SETS][$];   // ways, most recently used first
    int          m_ptr   [SETS];

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_rec[s].delete();
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_rec[s].push_back(w);
            end
            m_ptr[s] = 0;
        end
    endfunction

    function automatic void touch(input int s, input int way);
        for (int k = 0; k < m_rec[s].size(); k++) begin
            if (m_rec[s][k] == way) begin
                m_rec[s].delete(k);
                break;
            end
        end
        m_rec[s].push_front(way);
    endfunction

    function automatic bit model_access(input logic [63:0] addr);
        logic [63:0] line;
        int s;
        int way;
        line = addr >> 6;
        s    = int'(line[4:0]);
        way  = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_line[s][w] == line) way = w;
        if (way >= 0) begin
            touch(s, way);
            return 1'b1;
        end
        for (int w = 0; w < WAYS; w++)
            if (!m_valid[s][w] && way < 0) way = w;
        if (way < 0) begin
`ifdef ICACHE_LRU_EN
            way = m_rec[s][m_rec[s].size()-1];
`else
            way = m_ptr[s];
            m_ptr[s] = (m_ptr[s] + 1) % WAYS;
`endif
        end
        m_valid[s][way] = 1'b1;
        m_line[s][way]  = line;
        touch(s, way);
        return 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic [63:0] addr);
        int n;
        bit h;
        logic [7:0] lat;
        logic [63:0] la;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            fail_now("req_ready_wait");
            return;
        end
        la = {addr[63:6], 6'b0};
        h = model_access(addr);
        lat = h ? 8'd2 : ((gap_mode == 0) ? 8'(2 + BEATS) : 8'd255);
        if (!h) fill_exp_addr = la;
        exp_q.push_back({h, lat, 32'(cyc), exp_line(la)});
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now("resp_wait");
            exp_q.delete();
        end
    endtask

    task automatic access(input logic [63:0] addr);
        send_req(addr);
        wait_resp();
    endtask

    task automatic wait_beat(input int k);
        int n;
        n = 0;
        while (beat_idx != k && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (beat_idx != k) fail_now("beat_wait");
    endtask

    // Counts consecutive req_ready-low cycles starting at the current negedge.
    task automatic count_ready_low(input string name);
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(name, n, SETS);
    endtask

    task automatic flush_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        flush = 1'b1;
        model_clear();
        @(negedge clk);
        flush = 1'b0;
        count_ready_low("flush_idle_cycles");
    endtask

    // ---------------- memory responder ----------------
    initial begin
        bit alt;
        bit addr_chk;
        bit prev_req;
        bit present;
        alt = 0;
        addr_chk = 0;
        prev_req = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (!addr_chk) begin
                    check("mem_addr", mem_addr, fill_exp_addr);
                    addr_chk = 1;
                end
                present = (beat_idx < BEATS) &&
                          (gap_mode == 0 || (gap_mode == 1 && alt) ||
                           (gap_mode == 2 && $urandom_range(0, 1) == 1));
                alt = !alt;
                if (present) begin
                    mem_data_valid = 1'b1;
                    mem_data = mem_word(fill_exp_addr, beat_idx);
                    if (beat_idx == BEATS - 1) last_beat_cyc = cyc;
                    beat_idx++;
                end else begin
                    mem_data_valid = 1'b0;
                    mem_data = {$urandom, $urandom};
                end
            end else begin
                if (prev_req && reset_n && beat_idx < BEATS) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_req_held actual=0 required=1 beats=%0d", beat_idx);
                end
                beat_idx = 0;
                addr_chk = 0;
                alt = 0;
                // Stray beats while no fill is requested must be ignored.
                mem_data_valid = 1'($urandom_range(0, 1));
                mem_data = {$urandom, $urandom};
            end
            prev_req = mem_req;
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [EW-1:0] e;
        logic [7:0] lat;
        int acc;
        forever begin
            @(negedge clk);
            if (reset_n && resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    lat = e[EW-2 -: 8];
                    acc = int'(e[EW-10 -: 32]);
                    check("resp_hit", resp_hit, e[EW-1]);
                    check("resp_block", resp_block, e[LINE_BITS-1:0]);
                    if (lat == 8'd255) check("resp_after_last_beat", cyc, last_beat_cyc + 1);
                    else check("resp_latency", cyc - acc, lat);
                    if (!e[EW-1]) check("mem_req_drop_at_resp", mem_req, 0);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] a;
        model_clear();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_block", resp_block, 0);
        check("rst_resp_hit", resp_hit, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);

        // cold miss then hit on the same line
        gap_mode = 0;
        access(64'h1000);
        access(64'h1008);

        // fill with a beat every other cycle
        gap_mode = 1;
        access(64'h2040);
        gap_mode = 0;
        access(64'h2040);

        // flush in idle, then the line misses again
        flush_idle();
        access(64'h1000);

        // set conflict on index 0
        flush_idle();
        access(64'h0000);
        access(64'h0800);
        access(64'h1000);
        access(64'h1800);
        access(64'h0000);
        access(64'h2000);
        access(64'h0000);
        access(64'h0800);

        // flush pulse during a fill
        flush_idle();
        send_req(64'h1000);
        wait_beat(3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_resp();
        model_clear();
        @(negedge clk);
        count_ready_low("flush_after_fill_cycles");
        access(64'h1000);

        // reset in the middle of a fill
        send_req(64'h4080);
        wait_beat(4);
        reset_n = 1'b0;
        exp_q.delete();
        model_clear();
        repeat (2) @(negedge clk);
        check("midfill_rst_mem_req", mem_req, 0);
        check("midfill_rst_req_ready", req_ready, 0);
        reset_n = 1'b1;
        access(64'h1000);
        access(64'h4080);

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            gap_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 15) == 0) flush_idle();
            a = (64'($urandom_range(0, 5)) << 11) | (64'($urandom_range(0, 3)) << 6) |
                64'($urandom_range(0, 63)) | (64'($urandom_range(0, 1)) << 40);
            access(a);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
